// File: rtl/sdr_bist_pkg.sv
// Shared constants for the SDRAM Wishbone BIST master: FSM encodings, pattern
// modes, cycle-type codes and the LFSR definition.
package sdr_bist_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_BURST = 3'd1;
  localparam logic [2:0] ST_WR_GAP   = 3'd2;
  localparam logic [2:0] ST_RD_BURST = 3'd3;
  localparam logic [2:0] ST_RD_GAP   = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  localparam logic [1:0] MODE_INCR = 2'b00;
  localparam logic [1:0] MODE_LFSR = 2'b01;
  localparam logic [1:0] MODE_ADDR = 2'b10;
  localparam logic [1:0] MODE_WALK = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdr_wb_bist_master_if.sv
// Wishbone burst bus between the BIST master and the SDRAM controller slave port.
interface sdr_wb_bist_master_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/sdr_bist_pattern.sv
// Test-pattern generator shared by the write and read-compare phases; the
// read phase reseeds it so the same sequence is regenerated as expectation.
module sdr_bist_pattern
  import sdr_bist_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed,
  input  logic          step,
  input  logic [1:0]    mode,
  input  logic [31:0]   beat_idx,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [31:0] lfsr_q;
  logic [31:0] addr_ext;
  logic [31:0] core;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr_q <= LFSR_SEED;
    else if (seed) lfsr_q <= LFSR_SEED;
    else if (step) lfsr_q <= lfsr_next(lfsr_q);
  end

  if (AW >= 32) begin : g_addr_wide
    assign addr_ext = addr[31:0];
  end else begin : g_addr_narrow
    assign addr_ext = {{(32-AW){1'b0}}, addr};
  end

  always_comb begin
    core = beat_idx;
    case (mode)
      MODE_INCR: core = beat_idx;
      MODE_LFSR: core = lfsr_q;
      MODE_ADDR: core = addr_ext;
      default:   core = 32'd1 << beat_idx[4:0];
    endcase
  end

  // The 32-bit core value is replicated to fill buses wider than 32 bits.
  if (DW > 32) begin : g_dat_wide
    assign data = {core[DW-33:0], core};
  end else begin : g_dat_narrow
    assign data = core[DW-1:0];
  end

endmodule

// File: rtl/sdr_wb_bist_master.sv
// Wishbone burst BIST master: writes a patterned region into the SDRAM
// controller, reads it back and counts mismatching beats.
//
// state     | meaning
// IDLE      | waiting for start (one launch cycle after an accepted start)
// WR_BURST  | write burst in flight, cyc/stb/we high
// WR_GAP    | one idle bus cycle between write bursts / before read phase
// RD_BURST  | read burst in flight, each ack compared against pattern
// RD_GAP    | one idle bus cycle between read bursts / before finish
// FINISH    | done pulse, pass valid
module sdr_wb_bist_master
  import sdr_bist_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 26,
  parameter int BLW = 5,
  parameter int NBW = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [AW-1:0]        cfg_start_addr,
  input  logic [BLW-1:0]       cfg_bl,
  input  logic [NBW-1:0]       cfg_nburst,
  input  logic [1:0]           cfg_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          err_cnt,
  output logic [AW-1:0]        first_err_addr,
  sdr_wb_bist_master_if.master wb
);

  localparam logic [AW-1:0] ADDR_STEP = AW'(DW / 8);

  logic [2:0]     state_q, state_d;
  logic           launch_q;
  logic [AW-1:0]  start_addr_q;
  logic [AW-1:0]  addr_q;
  logic [BLW-1:0] bl_rld_q;
  logic [BLW-1:0] beat_left_q;
  logic [NBW-1:0] nburst_q;
  logic [NBW-1:0] burst_left_q;
  logic [1:0]     mode_q;
  logic [31:0]    beat_idx_q;
  logic [31:0]    err_cnt_q;
  logic [AW-1:0]  first_err_q;
  logic           pass_q;

  logic           accept;
  logic           in_burst;
  logic           beat_ack;
  logic           rd_ack;
  logic           last_beat;
  logic           in_gap;
  logic           rd_reseed;
  logic           mismatch;
  logic [BLW-1:0] bl_last_d;
  logic [DW-1:0]  pat_data;

  // A start landing on the done cycle sees state FINISH and is dropped; the
  // launch cycle also blocks a second start before the FSM leaves IDLE.
  assign accept    = start && (state_q == ST_IDLE) && !launch_q;
  assign in_burst  = (state_q == ST_WR_BURST) || (state_q == ST_RD_BURST);
  assign in_gap    = (state_q == ST_WR_GAP) || (state_q == ST_RD_GAP);
  assign beat_ack  = in_burst && wb.wb_ack_i;
  assign rd_ack    = (state_q == ST_RD_BURST) && wb.wb_ack_i;
  assign last_beat = (beat_left_q == '0);
  assign rd_reseed = (state_q == ST_WR_GAP) && (burst_left_q == '0);
  assign bl_last_d = (cfg_bl == '0) ? '0 : cfg_bl - 1'b1;
  assign mismatch  = (wb.wb_dat_i != pat_data);

  sdr_bist_pattern #(.DW(DW), .AW(AW)) u_pattern (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .seed     (accept || rd_reseed),
    .step     (beat_ack),
    .mode     (mode_q),
    .beat_idx (beat_idx_q),
    .addr     (addr_q),
    .data     (pat_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (launch_q) state_d = (nburst_q == '0) ? ST_FINISH : ST_WR_BURST;
      ST_WR_BURST: if (wb.wb_ack_i && last_beat) state_d = ST_WR_GAP;
      ST_WR_GAP:   state_d = (burst_left_q != '0) ? ST_WR_BURST : ST_RD_BURST;
      ST_RD_BURST: if (wb.wb_ack_i && last_beat) state_d = ST_RD_GAP;
      ST_RD_GAP:   state_d = (burst_left_q != '0) ? ST_RD_BURST : ST_FINISH;
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      launch_q     <= 1'b0;
      start_addr_q <= '0;
      addr_q       <= '0;
      bl_rld_q     <= '0;
      beat_left_q  <= '0;
      nburst_q     <= '0;
      burst_left_q <= '0;
      mode_q       <= MODE_INCR;
      beat_idx_q   <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      launch_q <= accept;

      if (accept) begin
        start_addr_q <= cfg_start_addr;
        addr_q       <= cfg_start_addr;
        bl_rld_q     <= bl_last_d;
        beat_left_q  <= bl_last_d;
        nburst_q     <= cfg_nburst;
        mode_q       <= cfg_mode;
        beat_idx_q   <= '0;
        err_cnt_q    <= '0;
        first_err_q  <= '0;
        pass_q       <= 1'b0;
      end

      if (launch_q) burst_left_q <= nburst_q - 1'b1;

      if (beat_ack) begin
        addr_q     <= addr_q + ADDR_STEP;
        beat_idx_q <= beat_idx_q + 32'd1;
        if (!last_beat) beat_left_q <= beat_left_q - 1'b1;
      end

      if (in_gap) begin
        beat_left_q <= bl_rld_q;
        if (burst_left_q != '0) burst_left_q <= burst_left_q - 1'b1;
        else                    burst_left_q <= nburst_q - 1'b1;
      end

      // Read phase walks the same region with the same beat numbering.
      if (rd_reseed) begin
        addr_q     <= start_addr_q;
        beat_idx_q <= '0;
      end

      if (rd_ack && mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
        if (err_cnt_q == '0) first_err_q <= addr_q;
      end

      if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) pass_q <= (err_cnt_q == '0);
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FINISH);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

  assign wb.wb_cyc_o  = in_burst;
  assign wb.wb_stb_o  = in_burst;
  assign wb.wb_we_o   = (state_q == ST_WR_BURST);
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = (state_q == ST_WR_BURST) ? pat_data : '0;
  assign wb.wb_sel_o  = '1;
  assign wb.wb_cti_o  = !in_burst ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);

endmodule

// File: tb/tb_sdr_wb_bist_master.sv
// Directed bench for sdr_wb_bist_master with a memory-backed Wishbone slave
// that can stall randomly and corrupt one chosen read beat.
module tb_sdr_wb_bist_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [25:0] cfg_start_addr;
  logic [4:0]  cfg_bl;
  logic [15:0] cfg_nburst;
  logic [1:0]  cfg_mode;
  logic        busy, done, pass;
  logic [31:0] err_cnt;
  logic [25:0] first_err_addr;

  int checks   = 0;
  int failures = 0;

  sdr_wb_bist_master_if #(.DW(32), .AW(26)) wb ();

  sdr_wb_bist_master #(.DW(32), .AW(26), .BLW(5), .NBW(16)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start          (start),
    .cfg_start_addr (cfg_start_addr),
    .cfg_bl         (cfg_bl),
    .cfg_nburst     (cfg_nburst),
    .cfg_mode       (cfg_mode),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .wb             (wb)
  );

  always #5 clk = ~clk;

  // ---------------- slave model (acts on the falling edge) ----------------
  bit          ack_rand   = 1'b0;
  int          corrupt_at = -1;
  logic [31:0] mem [0:1023];
  int          wr_acks = 0, rd_acks = 0;
  int          stall_seen = 0, stall_err = 0;
  int          wait_left = 0;
  bit          prev_stall = 1'b0;
  logic [25:0] p_addr;
  logic [31:0] p_dat;
  logic [2:0]  p_cti;
  logic        p_we;
  logic [25:0] lg_addr [0:511];
  logic [31:0] lg_dat  [0:511];
  logic [2:0]  lg_cti  [0:511];
  logic        lg_we   [0:511];
  int          lg_n = 0;

  always @(negedge clk) begin
    logic       bus;
    logic [9:0] idx;
    bus = wb.wb_cyc_o && wb.wb_stb_o;
    if (bus && prev_stall) begin
      stall_seen++;
      if (wb.wb_addr_o !== p_addr || wb.wb_dat_o !== p_dat ||
          wb.wb_cti_o !== p_cti || wb.wb_we_o !== p_we)
        stall_err++;
    end
    if (rst)                wb.wb_ack_i = 1'b0;
    else if (!ack_rand)     wb.wb_ack_i = 1'b1;
    else if (!bus)          wb.wb_ack_i = 1'b0;
    else if (wait_left > 0) begin wb.wb_ack_i = 1'b0; wait_left--; end
    else begin
      wb.wb_ack_i = 1'b1;
      wait_left   = $urandom_range(0, 5);
    end
    idx = wb.wb_addr_o[11:2];
    wb.wb_dat_i = mem[idx];
    if (!wb.wb_we_o && rd_acks == corrupt_at) wb.wb_dat_i = mem[idx] ^ 32'h1;
    if (bus && wb.wb_ack_i) begin
      if (lg_n < 512) begin
        lg_addr[lg_n] = wb.wb_addr_o;
        lg_we[lg_n]   = wb.wb_we_o;
        lg_cti[lg_n]  = wb.wb_cti_o;
        lg_dat[lg_n]  = wb.wb_we_o ? wb.wb_dat_o : wb.wb_dat_i;
      end
      lg_n++;
      if (wb.wb_we_o) begin mem[idx] = wb.wb_dat_o; wr_acks++; end
      else            rd_acks++;
    end
    prev_stall = bus && !wb.wb_ack_i;
    p_addr = wb.wb_addr_o;
    p_dat  = wb.wb_dat_o;
    p_cti  = wb.wb_cti_o;
    p_we   = wb.wb_we_o;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [25:0] a, input logic [4:0] bl, input logic [15:0] nb,
                    input logic [1:0] m);
    @(negedge clk);
    cfg_start_addr = a; cfg_bl = bl; cfg_nburst = nb; cfg_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, wr0, rd0, st0, found;
    rst = 1'b1; start = 1'b0;
    cfg_start_addr = '0; cfg_bl = '0; cfg_nburst = '0; cfg_mode = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("reset_bus_ctl", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_cti_o, wb.wb_sel_o},
        {3'b000, 3'b000, 4'hF});
    chk("reset_bus_addr_dat", {wb.wb_addr_o, wb.wb_dat_o}, 58'h0);
    chk("reset_status", {busy, done, pass}, 3'b000);
    chk("reset_err", {err_cnt, first_err_addr}, 58'h0);

    // T1: incrementing, 2 bursts of 4 at 0x100, ack held high
    base = lg_n;
    go(26'h100, 5'd4, 16'd2, 2'b00);
    chk("t1_cyc_after_edge0", wb.wb_cyc_o, 1'b0);
    @(negedge clk);
    chk("t1_cyc_after_edge1", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 3'b111);
    chk("t1_first_addr", wb.wb_addr_o, 26'h100);
    wait_done("t1_done", 100);
    chk("t1_pass_err", {pass, err_cnt}, {1'b1, 32'd0});
    chk("t1_beats", lg_n - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_beat%0d", i),
          {lg_we[base+i], lg_addr[base+i], lg_dat[base+i], lg_cti[base+i]},
          {(i < 8), 26'h100 + 26'(4 * (i % 8)), 32'(i % 8), ((i % 4) == 3) ? 3'b111 : 3'b010});
    end

    // T2: LFSR with read beat 3 corrupted
    base = lg_n;
    corrupt_at = rd_acks + 3;
    go(26'h100, 5'd4, 16'd2, 2'b01);
    chk("t2_pass_cleared", pass, 1'b0);
    wait_done("t2_done", 100);
    chk("t2_err_cnt", err_cnt, 32'd1);
    chk("t2_first_err_addr", first_err_addr, 26'h10C);
    chk("t2_pass", pass, 1'b0);
    chk("t2_lfsr_w0", lg_dat[base+0], 32'hACE1_0001);
    chk("t2_lfsr_w1", lg_dat[base+1], 32'hD650_8003);
    chk("t2_lfsr_w2", lg_dat[base+2], 32'hEB08_4002);
    @(negedge clk);
    chk("t2_done_one_cycle", done, 1'b0);
    chk("t2_pass_held", pass, 1'b0);
    corrupt_at = -1;

    // T3: random wait states, 3 bursts of 31
    ack_rand = 1'b1;
    base = lg_n; wr0 = wr_acks; rd0 = rd_acks; st0 = stall_seen;
    go(26'h200, 5'd31, 16'd3, 2'b00);
    wait_done("t3_done", 3000);
    chk("t3_write_acks", wr_acks - wr0, 93);
    chk("t3_read_acks", rd_acks - rd0, 93);
    chk("t3_stall_stable", stall_err, 0);
    chk("t3_stalls_happened", (stall_seen > st0), 1'b1);
    chk("t3_pass", {pass, err_cnt}, {1'b1, 32'd0});
    chk("t3_beat30", {lg_addr[base+30], lg_cti[base+30]}, {26'h278, 3'b111});
    chk("t3_beat31", {lg_addr[base+31], lg_cti[base+31]}, {26'h27C, 3'b010});
    chk("t3_beat92", {lg_we[base+92], lg_addr[base+92], lg_cti[base+92]}, {1'b1, 26'h370, 3'b111});
    ack_rand = 1'b0;

    // T4: address wrap, address-as-data
    base = lg_n;
    go(26'h3FF_FFFC, 5'd2, 16'd1, 2'b10);
    wait_done("t4_done", 100);
    chk("t4_beat0", {lg_addr[base], lg_dat[base], lg_cti[base]}, {26'h3FF_FFFC, 32'h03FF_FFFC, 3'b010});
    chk("t4_beat1", {lg_addr[base+1], lg_dat[base+1], lg_cti[base+1]}, {26'h0, 32'h0, 3'b111});
    chk("t4_pass", {pass, err_cnt}, {1'b1, 32'd0});

    // T5a: zero bursts, then a start coincident with done
    base = lg_n;
    go(26'h100, 5'd4, 16'd0, 2'b00);
    chk("t5_done_not_yet", done, 1'b0);
    @(negedge clk);
    chk("t5_done_two_cycles", {done, pass}, 2'b11);
    cfg_nburst = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_start_on_done_ignored", busy, 1'b0);
    chk("t5_no_cyc", lg_n - base, 0);

    // T5b: bl=0 gives single-beat bursts, walking-one data
    base = lg_n;
    go(26'h40, 5'd0, 16'd3, 2'b11);
    wait_done("t5b_done", 100);
    chk("t5b_beats", lg_n - base, 6);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5b_wr%0d", i),
          {lg_we[base+i], lg_addr[base+i], lg_dat[base+i], lg_cti[base+i]},
          {1'b1, 26'h40 + 26'(4 * i), 32'd1 << i, 3'b111});
    end
    chk("t5b_rd_cti", lg_cti[base+4], 3'b111);
    chk("t5b_pass", pass, 1'b1);

    // T6: reset in the middle of a read burst, then a clean rerun
    go(26'h100, 5'd4, 16'd2, 2'b00);
    found = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (wb.wb_cyc_o && !wb.wb_we_o) begin found = 1; break; end
    end
    chk("t6_reached_read", found, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_reset_drops_bus", {wb.wb_cyc_o, wb.wb_stb_o, busy}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_state_cleared", {err_cnt, pass, done}, 34'h0);
    go(26'h100, 5'd4, 16'd2, 2'b00);
    wait_done("t6_rerun_done", 100);
    chk("t6_rerun_pass", {pass, err_cnt}, {1'b1, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
